// File: rtl/crypto_dec_stream.sv
// crypto_dec_stream
// ---------------------------------------------------------------------------
// Iterative 8-bit stream decryptor. It undoes the team's round cipher, whose
// encrypt round r (r = 0..ROUNDS-1) is
//     x = rotl(x ^ k_r, ROT),  k_r = rotl(key, r mod 8).
// Decryption runs the rounds backwards, one per clock. Each round does
// x = rotr(x, ROT) ^ k_r. The round key starts at k_(ROUNDS-1) and is
// rotated right by one bit per round. That steps it down to k_(r-1).
//
// A byte is accepted in IDLE. The engine then spends exactly ROUNDS cycles
// in RUN and waits in DONE until the consumer takes the result.
//
// Parameters
//   ROUNDS      number of cipher rounds (1..8)
//   ROT         per-round rotate amount in bits (1..7)
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_key       cipher key, sampled only on the input handshake
//   i_in_valid  ciphertext byte present on i_in_data
//   o_in_ready  engine can accept a byte (state-derived, IDLE only)
//   i_in_data   ciphertext byte
//   o_out_valid plaintext byte present on o_out_data (DONE only)
//   i_out_ready consumer accepts o_out_data
//   o_out_data  plaintext byte; this is the working register, so it shows
//               round intermediates while in RUN
//   o_busy      high in RUN or DONE
//   o_byte_cnt  count of delivered plaintext bytes, wraps 255 -> 0
// ---------------------------------------------------------------------------
module crypto_dec_stream #(
    parameter int ROUNDS = 4,
    parameter int ROT    = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_key,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [7:0] i_in_data,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_out_data,
    output logic       o_busy,
    output logic [7:0] o_byte_cnt
);

    localparam int RK_INIT_SH = (ROUNDS - 1) % 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_x;
    logic [7:0] w_x_nxt;
    logic [7:0] r_rk;
    logic [7:0] w_rk_nxt;
    logic [2:0] r_rnd;
    logic [2:0] w_rnd_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_busy;

    // The top byte of {v,v} shifted left by n is v rotated left by n.
    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << (n % 8);
        return d[15:8];
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] v, input int n);
        return rotl8(v, 8 - (n % 8));
    endfunction

    // State and datapath registers. A reset abandons any byte in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_x     <= 8'h00;
            r_rk    <= 8'h00;
            r_rnd   <= 3'd0;
            r_cnt   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_rk    <= w_rk_nxt;
            r_rnd   <= w_rnd_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, round datapath and state-decoded handshake outputs.
    // The key is captured with the byte, so later key changes do not
    // affect a byte already in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_rk_nxt    = r_rk;
        w_rnd_nxt   = r_rnd;
        w_cnt_nxt   = r_cnt;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_x_nxt     = i_in_data;
                    w_rk_nxt    = rotl8(i_key, RK_INIT_SH);
                    w_rnd_nxt   = 3'(ROUNDS - 1);
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy    = 1'b1;
                w_x_nxt   = rotr8(r_x, ROT) ^ r_rk;
                w_rk_nxt  = rotr8(r_rk, 1);
                w_rnd_nxt = r_rnd - 3'd1;
                if (r_rnd == 3'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_busy      = w_busy;
    assign o_out_data  = r_x;
    assign o_byte_cnt  = r_cnt;

endmodule
